// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one square-root core among four requesters; grant-to-core_go latency 1 cycle.
// Losing or late requesters are held off (no req_ready) until the block returns to IDLE; aborts after TIMEOUT cycles.
module sqrt_arbiter #(
   parameter int TIMEOUT = 200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_n,
   output logic [3:0]  req_ready,
   output logic [3:0]  resp_valid,
   output logic [3:0]  resp_answer,
   output logic        resp_err,
   output logic        busy,
   output logic        core_go,
   output logic [7:0]  core_n,
   input  logic [3:0]  core_answer,
   input  logic        core_over,
   output logic        core_reset
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [3:0]    req_ready_q, req_ready_d;
   logic [3:0]    resp_valid_q, resp_valid_d;
   logic [3:0]    resp_answer_q, resp_answer_d;
   logic          resp_err_q, resp_err_d;
   logic          busy_q, busy_d;
   logic          core_go_q, core_go_d;
   logic [7:0]    core_n_q, core_n_d;
   logic          core_reset_q, core_reset_d;

   logic          sel_vld;
   logic [1:0]    sel_idx;
   logic [1:0]    cand;
   logic          tmo;

   assign tmo = (cnt_q == TMO);

   // Walk offsets from high to low so the smallest offset from rr_ptr wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = rr_ptr_q;
      cand    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand = rr_ptr_q + 2'(i);
         if (req_valid[cand]) begin
            sel_vld = 1'b1;
            sel_idx = cand;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_vld) state_d = RUN;
         RUN:     if (core_over || tmo) state_d = RELEASE;
         RELEASE: if (!core_over) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_d   = 4'd0;
      resp_valid_d  = 4'd0;
      resp_err_d    = 1'b0;
      core_reset_d  = 1'b0;
      resp_answer_d = resp_answer_q;
      core_go_d     = core_go_q;
      core_n_d      = core_n_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      rr_ptr_d      = rr_ptr_q;
      busy_d        = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               gnt_d       = sel_idx;
               req_ready_d = 4'b0001 << sel_idx;
               core_n_d    = req_n[{sel_idx, 3'b000} +: 8];
               core_go_d   = 1'b1;
               cnt_d       = '0;
            end
         end
         RUN: begin
            // core_over takes priority over a simultaneous timeout
            if (core_over) begin
               resp_valid_d  = 4'b0001 << gnt_q;
               resp_answer_d = core_answer;
               core_go_d     = 1'b0;
            end else if (tmo) begin
               resp_valid_d  = 4'b0001 << gnt_q;
               resp_err_d    = 1'b1;
               resp_answer_d = 4'd0;
               core_reset_d  = 1'b1;
               core_go_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            if (!core_over) rr_ptr_d = gnt_q + 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         rr_ptr_q      <= 2'd0;
         gnt_q         <= 2'd0;
         req_ready_q   <= 4'd0;
         resp_valid_q  <= 4'd0;
         resp_answer_q <= 4'd0;
         resp_err_q    <= 1'b0;
         busy_q        <= 1'b0;
         core_go_q     <= 1'b0;
         core_n_q      <= 8'd0;
         core_reset_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         gnt_q         <= gnt_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_answer_q <= resp_answer_d;
         resp_err_q    <= resp_err_d;
         busy_q        <= busy_d;
         core_go_q     <= core_go_d;
         core_n_q      <= core_n_d;
         core_reset_q  <= core_reset_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_answer = resp_answer_q;
   assign resp_err    = resp_err_q;
   assign busy        = busy_q;
   assign core_go     = core_go_q;
   assign core_n      = core_n_q;
   assign core_reset  = core_reset_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt core, per-requester drivers and an expected-grant/response scoreboard.
module tb_sqrt_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = 4'd0;
   logic [31:0] req_n = 32'd0;
   logic [3:0]  req_ready;
   logic [3:0]  resp_valid;
   logic [3:0]  resp_answer;
   logic        resp_err;
   logic        busy;
   logic        core_go;
   logic [7:0]  core_n;
   logic [3:0]  core_answer = 4'd0;
   logic        core_over = 1'b0;
   logic        core_reset;

   sqrt_arbiter #(.TIMEOUT(200)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_answer(resp_answer), .resp_err(resp_err),
      .busy(busy), .core_go(core_go), .core_n(core_n),
      .core_answer(core_answer), .core_over(core_over), .core_reset(core_reset)
   );

   always #5 clock = ~clock;

   typedef struct { int idx; int n; } gnt_t;
   typedef struct { int idx; int ans; int err; } resp_t;
   gnt_t  exp_gnt[$];
   resp_t exp_resp[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // core model and monitor state
   int  core_delay = 5;
   int  sticky_hold = 0;
   bit  core_never = 1'b0;
   int  ccnt = 0;
   int  scnt = 0;
   bit  go_prev = 1'b0;
   bit  first_go = 1'b1;
   int  gap = 0;
   int  go_cyc = 0;
   int  over_last = -100;
   int  last_ans = 0;
   int  n_hold = 0;
   bit  chk_rst_clear = 1'b0;
   logic [3:0] rereq = 4'd0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   task automatic req(input int i, input int n);
      req_n[8*i +: 8] = 8'(n);
      req_valid[i] = 1'b1;
   endtask

   task automatic tick();
      gnt_t  g;
      resp_t r;
      @(negedge clock);
      cyc++;
      if (core_go && !go_prev) begin
         if (!first_go) check("go_gap_ge2", int'(gap >= 2), 1);
         first_go = 1'b0;
         go_cyc = cyc;
         n_hold = int'(core_n);
         gap = 0;
      end
      if (core_go && go_prev && int'(core_n) != n_hold) check("core_n_stable", core_n, n_hold);
      if (!core_go) gap++;
      go_prev = core_go;

      if (req_ready != 4'd0) begin
         if (exp_gnt.size() == 0) begin
            check("unexpected_ready", req_ready, 0);
         end else begin
            g = exp_gnt.pop_front();
            check("req_ready", req_ready, 1 << g.idx);
            check("core_n", core_n, g.n);
            check("core_go_at_grant", core_go, 1);
            check("busy_at_grant", busy, 1);
            check("grant_after_over_low", int'(cyc - over_last >= 3), 1);
         end
         req_valid = req_valid & ~req_ready;
      end

      if (chk_rst_clear) begin
         check("core_reset_one_cycle", core_reset, 0);
         chk_rst_clear = 1'b0;
      end

      if (resp_valid != 4'd0) begin
         if (exp_resp.size() == 0) begin
            check("unexpected_resp", resp_valid, 0);
         end else begin
            r = exp_resp.pop_front();
            check("resp_valid", resp_valid, 1 << r.idx);
            check("resp_answer", resp_answer, r.ans);
            check("resp_err", resp_err, r.err);
            check("core_reset_with_err", core_reset, r.err);
            check("core_go_low_at_resp", core_go, 0);
            if (r.err != 0) begin
               check("timeout_latency", cyc - go_cyc, 201);
               chk_rst_clear = 1'b1;
            end
            if (rereq[r.idx]) begin
               req_valid[r.idx] = 1'b1;
               rereq[r.idx] = 1'b0;
            end
         end
         last_ans = int'(resp_answer);
      end else begin
         if (resp_err) check("err_without_valid", resp_err, 0);
         if (int'(resp_answer) != last_ans) check("answer_hold", resp_answer, last_ans);
      end

      // behavioural square-root core
      if (core_reset) begin
         core_over = 1'b0;
         ccnt = 0;
      end else if (core_go) begin
         if (!core_over && !core_never) begin
            ccnt++;
            if (ccnt >= core_delay) begin
               core_over = 1'b1;
               core_answer = 4'(isqrt(int'(core_n)));
               ccnt = 0;
               scnt = 0;
            end
         end
      end else if (core_over) begin
         scnt++;
         if (scnt > sticky_hold) core_over = 1'b0;
      end else begin
         ccnt = 0;
      end
      if (core_over) over_last = cyc;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_answer"}, resp_answer, 0);
      check({tag, "_resp_err"}, resp_err, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_core_go"}, core_go, 0);
      check({tag, "_core_n"}, core_n, 0);
      check({tag, "_core_reset"}, core_reset, 0);
   endtask

   task automatic clear_model();
      core_over = 1'b0;
      ccnt = 0;
      scnt = 0;
      go_prev = 1'b0;
      first_go = 1'b1;
      gap = 0;
      over_last = -100;
      last_ans = 0;
      chk_rst_clear = 1'b0;
      rereq = 4'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 4'd0;
      clear_model();
      tick();
      tick();
      check_outputs_zero("reset");
      reset = 1'b0;
   endtask

   task automatic drain(input string tag, input int bound);
      int k = 0;
      while ((exp_gnt.size() != 0 || exp_resp.size() != 0 || busy) && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_pending"}, exp_gnt.size() + exp_resp.size(), 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      // single request
      do_reset();
      core_delay = 20;
      exp_gnt.push_back('{0, 48});
      exp_resp.push_back('{0, 6, 0});
      req(0, 48);
      drain("single", 200);

      // all four requesting
      do_reset();
      core_delay = 5;
      exp_gnt.push_back('{0, 255}); exp_resp.push_back('{0, 15, 0});
      exp_gnt.push_back('{1, 144}); exp_resp.push_back('{1, 12, 0});
      exp_gnt.push_back('{2, 0});   exp_resp.push_back('{2, 0, 0});
      exp_gnt.push_back('{3, 48});  exp_resp.push_back('{3, 6, 0});
      req(0, 255); req(1, 144); req(2, 0); req(3, 48);
      drain("all4", 300);

      // fairness: 0 re-requests at once, 1 still goes first
      do_reset();
      core_delay = 4;
      exp_gnt.push_back('{0, 100}); exp_resp.push_back('{0, 10, 0});
      exp_gnt.push_back('{1, 9});   exp_resp.push_back('{1, 3, 0});
      exp_gnt.push_back('{0, 100}); exp_resp.push_back('{0, 10, 0});
      rereq[0] = 1'b1;
      req(0, 100); req(1, 9);
      drain("fair", 300);

      // request withdrawn before it could be granted
      do_reset();
      core_delay = 10;
      exp_gnt.push_back('{0, 16}); exp_resp.push_back('{0, 4, 0});
      req(0, 16);
      for (int k = 0; k < 3; k++) tick();
      req(3, 200);
      tick();
      tick();
      req_valid[3] = 1'b0;
      drain("withdraw", 200);

      // timeout
      do_reset();
      core_never = 1'b1;
      exp_gnt.push_back('{2, 77}); exp_resp.push_back('{2, 0, 1});
      req(2, 77);
      drain("timeout", 400);
      tick();
      core_never = 1'b0;

      // sticky core_over delays the next grant
      do_reset();
      core_delay = 6;
      sticky_hold = 3;
      exp_gnt.push_back('{0, 81}); exp_resp.push_back('{0, 9, 0});
      exp_gnt.push_back('{1, 25}); exp_resp.push_back('{1, 5, 0});
      req(0, 81); req(1, 25);
      drain("sticky", 300);
      sticky_hold = 0;

      // reset mid-RUN
      do_reset();
      core_delay = 20;
      exp_gnt.push_back('{1, 200});
      req(1, 200);
      for (int k = 0; k < 20 && exp_gnt.size() != 0; k++) tick();
      check("mid_grant_seen", exp_gnt.size(), 0);
      for (int k = 0; k < 4; k++) tick();
      check("mid_busy_before_reset", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("mid_reset");
      clear_model();
      req(1, 200);
      tick();
      tick();
      check_outputs_zero("mid_reset_hold");
      reset = 1'b0;
      exp_gnt.push_back('{1, 200}); exp_resp.push_back('{1, 14, 0});
      drain("mid_regrant", 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 200: maximum clock cycles allowed from core_go rise to core_over before abort.
REQ-002 Port list:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- req_valid, input, 4, per-requester request; held with req_n until accepted.
- req_n, input, 32, operands; requester i uses bits [8i+7:8i].
- req_ready, output, 4, one-hot, one-cycle accept pulse.
- resp_valid, output, 4, one-hot, one-cycle result pulse to the granted requester.
- resp_answer, output, 4, shared result bus; valid only while a resp_valid bit is high.
- resp_err, output, 1, high with resp_valid when the result was aborted by timeout.
- busy, output, 1, high whenever the state is not IDLE.
- core_go, output, 1, level start to the shared square-root core.
- core_n, output, 8, operand to the core; held stable while core_go is high.
- core_answer, input, 4, floor(sqrt(core_n)) from the core; valid while core_over is high.
- core_over, input, 1, core completion level.
- core_reset, output, 1, one-cycle reset pulse to the core on timeout.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 States SHALL be IDLE, RUN and RELEASE.
REQ-005 In IDLE with req_valid nonzero, the block SHALL grant the first set bit at or after rr_ptr, searching upward modulo 4.
REQ-006 On a grant, in the next cycle the block SHALL pulse req_ready[g], load core_n from requester g's operand, raise core_go, clear the cycle counter and enter RUN.
REQ-007 Latency from req_valid sampled in IDLE to core_go high SHALL be 1 cycle.
REQ-008 A request withdrawn before its grant SHALL be ignored, and no req_ready SHALL be issued for it.
REQ-009 In RUN, core_go SHALL stay high and core_n stable; the counter SHALL increment each cycle and saturate at TIMEOUT.
REQ-010 In RUN, when core_over is sampled high, the next cycle SHALL produce all of the following:
- resp_answer = core_answer
- resp_valid[g] = 1 for one cycle
- resp_err = 0
- core_go = 0
- state RELEASE
REQ-011 In RUN, when the counter reaches TIMEOUT with core_over low, the next cycle SHALL produce all of the following:
- resp_valid[g] = 1 with resp_err = 1 and resp_answer = 0
- core_reset = 1 for one cycle
- core_go = 0
- state RELEASE
REQ-012 If core_over and the timeout occur in the same cycle, core_over SHALL win and no error SHALL be reported.
REQ-013 In RELEASE, the block SHALL wait until core_over is low, then set rr_ptr = (g+1) mod 4 and return to IDLE.
REQ-014 RELEASE SHALL last at least one cycle, so back-to-back grants are separated by at least 2 cycles without core_go.
REQ-015 New req_valid activity during RUN or RELEASE SHALL be held off, and no req_ready SHALL be issued.
REQ-016 resp_answer SHALL hold its last value between responses; resp_err SHALL be 0 whenever resp_valid is 0.
REQ-017 A requester continuously requesting SHALL wait at most 3 other transactions before its grant.

Reset
REQ-018 While reset is high, the block SHALL asynchronously force:
- state = IDLE and rr_ptr = 0
- req_ready, resp_valid, resp_answer = 0
- resp_err, busy, core_go = 0
- core_n = 0 and core_reset = 0
REQ-019 Reset during RUN or RELEASE SHALL abort the transaction with no resp_valid issued; requests SHALL be re-arbitrated after release.
REQ-020 The first grant after reset release SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-021 Single request: req_valid=0001, N0=48, core returns over after 20 cycles -> req_ready=0001 one cycle, core_n=48, resp_valid=0001, resp_answer=6, resp_err=0.
REQ-022 All four requesting with N=255,144,0,48 and rr_ptr=0 -> grants in order 0,1,2,3, answers 15,12,0,6, with core_go low at least 2 cycles between grants.
REQ-023 Fairness: requester 0 re-requests immediately after its response while 1 is pending -> requester 1 is granted before requester 0.
REQ-024 Timeout: core_over never rises, TIMEOUT=200 -> resp_valid with resp_err=1 and resp_answer=0 exactly 201 cycles after core_go rose, plus a one-cycle core_reset pulse.
REQ-025 Reset mid-RUN: reset asserted 5 cycles after the grant -> all outputs 0 immediately and no resp_valid; after release, the still-pending request is re-granted and completes correctly.
REQ-026 Sticky core_over held high 3 cycles after completion -> the block stays in RELEASE and grants the next request only after core_over falls.
